// File: rtl/kernel_cache_read_arbiter_pkg.sv
// Shared constants and state encoding for the kernel cache read arbiter.
// AR attributes are fixed: 64-byte beats, INCR bursts, normal non-cacheable bufferable.
package PKG_CACHE;

    localparam logic [2:0] AR_SIZE_64B = 3'd6;
    localparam logic [1:0] AR_BURST_INCR = 2'b01;
    localparam logic [3:0] AR_CACHE_ATTR = 4'b0011;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/kernel_cache_read_arbiter_rr.sv
// Round-robin pick: first eligible requester at or above i_rr_ptr, wrapping.
// Purely combinational; o_grant is all-zero when nothing is eligible.
module arbiter_round_robin #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_eligible,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;

    always_comb begin
        // Rotate so the pointer position lands at bit 0, then priority-encode.
        w_rot = N'({i_eligible, i_eligible} >> i_rr_ptr);
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = IDX_W'(k);
        end
        w_sum = {1'b0, i_rr_ptr} + {1'b0, w_off};
        if (w_sum >= (IDX_W + 1)'(N)) w_sum = w_sum - (IDX_W + 1)'(N);
        o_idx   = w_sum[IDX_W-1:0];
        o_grant = (|w_rot) ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/kernel_cache_read_arbiter.sv
// Arbitrates NUM_REQ read requesters onto one AXI AR channel and routes R beats back by ID.
// Each requester is limited to MAX_OUTSTANDING bursts in flight.
module kernel_cache_read_arbiter
    import PKG_CACHE::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ID_W            = 4
) (
    input  logic                    ap_clk,
    input  logic                    areset,
    input  logic                    cache_setup_signal,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*64-1:0]   req_addr,
    input  logic [NUM_REQ*8-1:0]    req_len,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [511:0]            rsp_data,
    output logic                    rsp_last,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic                    s_arvalid,
    input  logic                    s_arready,
    output logic [63:0]             s_araddr,
    output logic [7:0]              s_arlen,
    output logic [ID_W-1:0]         s_arid,
    output logic [2:0]              s_arsize,
    output logic [1:0]              s_arburst,
    output logic [3:0]              s_arcache,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    input  logic [511:0]            s_rdata,
    input  logic                    s_rlast,
    input  logic [ID_W-1:0]         s_rid,
    input  logic [1:0]              s_rresp,
    output logic                    err_bad_id,
    output logic                    err_rresp
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    arb_state_t r_state, w_state_nxt;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_grant;
    logic               w_ar_hs;
    logic [63:0]        w_sel_addr;
    logic [7:0]         w_sel_len;
    logic [ID_W:0]      w_rid_ext;
    logic               w_rid_ok;

    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic               r_arvalid;
    logic [63:0]        r_araddr;
    logic [7:0]         r_arlen;
    logic [ID_W-1:0]    r_arid;
    logic [NUM_REQ-1:0] r_req_ready;
    logic               r_err_bad_id;
    logic               r_err_rresp;

    arbiter_round_robin #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_eligible (w_elig),
        .i_rr_ptr   (r_rr_ptr),
        .o_grant    (w_gnt_oh),
        .o_idx      (w_gnt_idx)
    );

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_INIT:  if (!cache_setup_signal) w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (cache_setup_signal) begin
                    w_state_nxt = ST_INIT;
                end else if (|w_gnt_oh) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            // A presented AR stays up until accepted, regardless of setup.
            ST_ISSUE: if (s_arready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_INIT;
        endcase
    end

    assign w_ar_hs = (r_state == ST_ISSUE) && s_arready;

    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_oh[k]) begin
                w_sel_addr = req_addr[k*64 +: 64];
                w_sel_len  = req_len[k*8 +: 8];
            end
        end
    end

    // req_ready is registered so no output follows req_valid combinationally;
    // it pulses in the cycle the captured request is first presented on AR.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            r_req_ready <= '0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_arid      <= '0;
            r_gnt_idx   <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_req_ready <= w_grant ? w_gnt_oh : '0;
            if (w_grant) begin
                r_arvalid <= 1'b1;
                r_araddr  <= w_sel_addr;
                r_arlen   <= w_sel_len;
                r_arid    <= ID_W'(w_gnt_idx);
                r_gnt_idx <= w_gnt_idx;
            end else if (w_ar_hs) begin
                r_arvalid <= 1'b0;
                r_rr_ptr  <= (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + IDX_W'(1);
            end
        end
    end

    assign w_rid_ext = {1'b0, s_rid};
    assign w_rid_ok  = w_rid_ext < (ID_W + 1)'(NUM_REQ);

    // Out-of-range IDs keep s_rready high so stray beats are drained.
    always_comb begin
        rsp_valid = '0;
        s_rready  = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_rid_ext == (ID_W + 1)'(k)) begin
                rsp_valid[k] = s_rvalid;
                s_rready     = rsp_ready[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        logic             w_inc;
        logic             w_dec;

        assign w_inc     = w_ar_hs && (r_gnt_idx == IDX_W'(k));
        assign w_dec     = s_rvalid && s_rready && s_rlast && (w_rid_ext == (ID_W + 1)'(k));
        assign w_elig[k] = req_valid[k] && (r_cnt < CNT_MAX);

        always_ff @(posedge ap_clk or posedge areset) begin
            if (areset)
                r_cnt <= '0;
            else if (w_inc && !w_dec && r_cnt != CNT_MAX)
                r_cnt <= r_cnt + CNT_W'(1);
            else if (w_dec && !w_inc && r_cnt != '0)
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            r_err_bad_id <= 1'b0;
            r_err_rresp  <= 1'b0;
        end else if (s_rvalid && s_rready) begin
            if (!w_rid_ok)        r_err_bad_id <= 1'b1;
            if (s_rresp != 2'b00) r_err_rresp  <= 1'b1;
        end
    end

    assign req_ready  = r_req_ready;
    assign s_arvalid  = r_arvalid;
    assign s_araddr   = r_araddr;
    assign s_arlen    = r_arlen;
    assign s_arid     = r_arid;
    assign s_arsize   = AR_SIZE_64B;
    assign s_arburst  = AR_BURST_INCR;
    assign s_arcache  = AR_CACHE_ATTR;
    assign rsp_data   = s_rdata;
    assign rsp_last   = s_rlast;
    assign err_bad_id = r_err_bad_id;
    assign err_rresp  = r_err_rresp;

endmodule

// File: tb/tb_kernel_cache_read_arbiter.sv
// Directed-plus-random bench for kernel_cache_read_arbiter against a counter/queue model
// of grants, outstanding bursts and R routing.
module tb_kernel_cache_read_arbiter;

    localparam int NR = 4;
    localparam int MO = 8;
    localparam int IW = 4;

    logic               ap_clk;
    logic               areset;
    logic               cache_setup_signal;
    logic [NR-1:0]      req_valid;
    logic [NR*64-1:0]   req_addr;
    logic [NR*8-1:0]    req_len;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      rsp_valid;
    logic [511:0]       rsp_data;
    logic               rsp_last;
    logic [NR-1:0]      rsp_ready;
    logic               s_arvalid;
    logic               s_arready;
    logic [63:0]        s_araddr;
    logic [7:0]         s_arlen;
    logic [IW-1:0]      s_arid;
    logic [2:0]         s_arsize;
    logic [1:0]         s_arburst;
    logic [3:0]         s_arcache;
    logic               s_rvalid;
    logic               s_rready;
    logic [511:0]       s_rdata;
    logic               s_rlast;
    logic [IW-1:0]      s_rid;
    logic [1:0]         s_rresp;
    logic               err_bad_id;
    logic               err_rresp;

    logic [63:0] a_addr [NR];
    logic [7:0]  a_len  [NR];

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign req_addr[g*64 +: 64] = a_addr[g];
        assign req_len[g*8 +: 8]    = a_len[g];
    end

    kernel_cache_read_arbiter #(
        .NUM_REQ         (NR),
        .MAX_OUTSTANDING (MO),
        .ID_W            (IW)
    ) dut (
        .ap_clk             (ap_clk),
        .areset             (areset),
        .cache_setup_signal (cache_setup_signal),
        .req_valid          (req_valid),
        .req_addr           (req_addr),
        .req_len            (req_len),
        .req_ready          (req_ready),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .rsp_last           (rsp_last),
        .rsp_ready          (rsp_ready),
        .s_arvalid          (s_arvalid),
        .s_arready          (s_arready),
        .s_araddr           (s_araddr),
        .s_arlen            (s_arlen),
        .s_arid             (s_arid),
        .s_arsize           (s_arsize),
        .s_arburst          (s_arburst),
        .s_arcache          (s_arcache),
        .s_rvalid           (s_rvalid),
        .s_rready           (s_rready),
        .s_rdata            (s_rdata),
        .s_rlast            (s_rlast),
        .s_rid              (s_rid),
        .s_rresp            (s_rresp),
        .err_bad_id         (err_bad_id),
        .err_rresp          (err_rresp)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int checks   = 0;
    int failures = 0;

    // Model: outstanding bursts, round-robin pointer, the AR currently presented.
    int          m_cnt [NR];
    int          m_rr;
    bit          m_issue;
    int          m_pend;
    logic [63:0] m_araddr;
    logic [7:0]  m_arlen;
    int          gnt_cnt;
    int          gq[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] elig, input int rr);
        for (int j = 0; j < NR; j++) begin
            int c;
            c = (rr + j) % NR;
            if (((elig >> c) & 4'b0001) != 4'b0000) return c;
        end
        return -1;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int cnt_sum();
        int s = 0;
        for (int k = 0; k < NR; k++) s += m_cnt[k];
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NR; k++) m_cnt[k] = 0;
        m_rr    = 0;
        m_issue = 0;
        m_pend  = 0;
    endtask

    // One clock: capture pre-edge inputs, advance, then check AR-side outputs against the model.
    task automatic tick();
        logic [NR-1:0] elig;
        logic [63:0]   p_addr [NR];
        logic [7:0]    p_len  [NR];
        logic          ar_hs;
        logic          r_dec;
        int            rid;
        int            pick;
        int            obs_idx;
        logic [NR-1:0] exp_rdy;
        #2;
        for (int k = 0; k < NR; k++) elig[k] = req_valid[k] && (m_cnt[k] < MO);
        p_addr = a_addr;
        p_len  = a_len;
        ar_hs  = m_issue && s_arready;
        rid    = int'(s_rid);
        r_dec  = s_rvalid && s_rlast && (rid < NR) && (((rsp_ready >> rid) & 4'b0001) != 4'b0000);
        @(posedge ap_clk);
        #1;
        if (ar_hs) begin
            if (m_cnt[m_pend] < MO) m_cnt[m_pend]++;
            m_rr    = (m_pend + 1) % NR;
            m_issue = 0;
        end
        if (r_dec && m_cnt[rid] > 0) m_cnt[rid]--;
        if (req_ready !== '0) begin
            gnt_cnt++;
            obs_idx = -1;
            for (int k = 0; k < NR; k++) if (req_ready[k]) obs_idx = k;
            gq.push_back(obs_idx);
            pick    = (!m_issue && elig != '0) ? rr_pick(elig, m_rr) : -1;
            exp_rdy = (pick >= 0) ? (4'(1) << pick) : '0;
            chk("grant_onehot", req_ready, exp_rdy);
            if (pick >= 0) begin
                m_issue  = 1;
                m_pend   = pick;
                m_araddr = p_addr[pick];
                m_arlen  = p_len[pick];
                chk("arsize", s_arsize, 3'd6);
                chk("arburst", s_arburst, 2'b01);
                chk("arcache", s_arcache, 4'b0011);
                a_addr[pick] = {$urandom, $urandom};
                a_len[pick]  = 8'($urandom);
            end
        end
        chk("arvalid", s_arvalid, m_issue);
        if (m_issue) begin
            chk("araddr", s_araddr, m_araddr);
            chk("arlen", s_arlen, m_arlen);
            chk("arid", s_arid, m_pend);
        end
    endtask

    task automatic wait_grant(input string tag, input int bound);
        int g0 = gnt_cnt;
        for (int i = 0; i < bound && gnt_cnt == g0; i++) tick();
        chk(tag, gnt_cnt - g0, 1);
    endtask

    // Return rlast beats (some with rlast=0 or rsp_ready low) until the model shows nothing in flight.
    task automatic drain();
        int guard = 0;
        int k;
        req_valid = '0;
        s_arready = 1'b1;
        tick();
        tick();
        while (cnt_sum() > 0 && guard < 400) begin
            k = 0;
            for (int j = NR - 1; j >= 0; j--) if (m_cnt[j] > 0) k = j;
            s_rvalid  = 1'b1;
            s_rid     = IW'(k);
            s_rlast   = 1'($urandom);
            s_rdata   = rnd512();
            s_rresp   = 2'b00;
            rsp_ready = 4'($urandom);
            #1;
            chk("rt_valid", rsp_valid, 4'(1) << k);
            chk("rt_rready", s_rready, (rsp_ready >> k) & 4'b0001);
            chk("rt_data", rsp_data, s_rdata);
            chk("rt_last", rsp_last, s_rlast);
            tick();
            guard++;
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        chk("drain_done", cnt_sum(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int exp_order [6];
        exp_order = '{0, 1, 2, 3, 0, 1};

        areset             = 1'b1;
        cache_setup_signal = 1'b1;
        req_valid          = 4'b1111;
        for (int k = 0; k < NR; k++) begin
            a_addr[k] = {$urandom, $urandom};
            a_len[k]  = 8'($urandom);
        end
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rlast   = 1'b0;
        s_rid     = '0;
        s_rresp   = 2'b00;
        rsp_ready = '0;
        gnt_cnt   = 0;
        model_reset();

        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_arvalid", s_arvalid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_araddr", s_araddr, 0);
        chk("rst_arid", s_arid, 0);
        chk("rst_arlen", s_arlen, 0);
        chk("rst_err_bad_id", err_bad_id, 0);
        chk("rst_err_rresp", err_rresp, 0);
        areset = 1'b0;

        // Setup held high: nothing may be granted.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("setup_no_ready", req_ready, 0);
        end
        s_arready          = 1'b1;
        cache_setup_signal = 1'b0;
        tick();
        chk("init_exit_no_grant", req_ready, 0);
        tick();
        chk("first_grant", req_ready, 4'b0001);

        // All valid, AR always ready: one grant every two cycles in round-robin order.
        g0 = gnt_cnt;
        repeat (20) tick();
        chk("ar_rate", gnt_cnt - g0, 10);
        for (int i = 0; i < 6; i++) chk("rr_order", (i < gq.size()) ? gq[i] : -1, exp_order[i]);

        drain();

        // Single requester saturates at MAX_OUTSTANDING; one rlast frees one slot.
        req_valid = 4'b0100;
        g0 = gnt_cnt;
        repeat (40) tick();
        chk("r2_cap", gnt_cnt - g0, MO);
        chk("r2_blocked", req_ready, 0);
        s_rvalid  = 1'b1;
        s_rid     = 4'd2;
        s_rlast   = 1'b1;
        s_rdata   = rnd512();
        rsp_ready = 4'b0100;
        #1;
        chk("r2_rready", s_rready, 1);
        chk("r2_rsp_valid", rsp_valid, 4'b0100);
        tick();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        repeat (10) tick();
        chk("r2_one_more", gnt_cnt - g0, MO + 1);

        // AR back-pressured while setup toggles: fields must hold.
        req_valid = 4'b0010;
        s_arready = 1'b0;
        wait_grant("r1_grant", 10);
        req_valid = '0;
        a_addr[1] = {$urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            cache_setup_signal = (i % 2 == 1);
            tick();
        end
        cache_setup_signal = 1'b0;
        s_arready          = 1'b1;
        tick();
        chk("ar_done", s_arvalid, 0);

        // Setup raised in IDLE blocks grants until it drops again.
        cache_setup_signal = 1'b1;
        req_valid          = 4'b0001;
        g0 = gnt_cnt;
        repeat (3) tick();
        chk("setup_idle_nogrant", gnt_cnt - g0, 0);
        cache_setup_signal = 1'b0;
        repeat (3) tick();
        chk("after_setup_grant", gnt_cnt - g0, 1);
        req_valid = '0;
        tick();

        // Out-of-range ID is drained and flagged; nonzero rresp is flagged.
        s_rvalid  = 1'b1;
        s_rid     = 4'd5;
        s_rlast   = 1'b1;
        rsp_ready = '0;
        #1;
        chk("bad_rready", s_rready, 1);
        chk("bad_rsp_valid", rsp_valid, 0);
        chk("bad_err_pre", err_bad_id, 0);
        tick();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        chk("err_bad_id", err_bad_id, 1);
        repeat (3) tick();
        chk("err_bad_id_sticky", err_bad_id, 1);
        chk("err_rresp_clear", err_rresp, 0);
        s_rvalid  = 1'b1;
        s_rid     = 4'd0;
        s_rresp   = 2'b10;
        rsp_ready = 4'b0001;
        s_rdata   = rnd512();
        #1;
        chk("rresp_rsp_valid", rsp_valid, 4'b0001);
        chk("rresp_data", rsp_data, s_rdata);
        tick();
        s_rvalid = 1'b0;
        s_rresp  = 2'b00;
        chk("err_rresp", err_rresp, 1);

        // rlast for requester 1 on the same edge as its AR handshake: count unchanged.
        req_valid = 4'b0010;
        s_arready = 1'b0;
        wait_grant("r1_grant2", 10);
        req_valid = '0;
        s_arready = 1'b1;
        s_rvalid  = 1'b1;
        s_rid     = 4'd1;
        s_rlast   = 1'b1;
        rsp_ready = 4'b0010;
        tick();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        req_valid = 4'b0010;
        g0 = gnt_cnt;
        repeat (30) tick();
        chk("r1_fill", gnt_cnt - g0, MO - 1);
        req_valid = '0;
        tick();

        // Reset asserted while an AR is presented drops everything immediately.
        req_valid = 4'b0001;
        s_arready = 1'b0;
        wait_grant("r0_grant", 10);
        req_valid = 4'b1111;
        #2;
        areset = 1'b1;
        #1;
        chk("mid_rst_arvalid", s_arvalid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_araddr", s_araddr, 0);
        chk("mid_rst_arid", s_arid, 0);
        chk("mid_rst_err_bad_id", err_bad_id, 0);
        chk("mid_rst_err_rresp", err_rresp, 0);
        model_reset();
        s_arready = 1'b1;
        @(posedge ap_clk);
        #1;
        areset = 1'b0;
        tick();
        chk("post_rst_init", req_ready, 0);
        tick();
        chk("post_rst_grant", req_ready, 4'b0001);
        req_valid = '0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
